// File: rtl/tof_pkg.sv
// Shared types for the time-of-flight echo detector: FSM states, count/hold widths
// and the small helpers that derive the window's last sample and the effective hold length.
package tof_pkg;

   localparam int CNT_W  = 16;
   localparam int HOLD_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_BLANK  = 3'd1,
      ST_SEARCH = 3'd2,
      ST_PEAK   = 3'd3,
      ST_DONE   = 3'd4
   } tof_state_e;

   // A zero timeout means an unbounded window; stopping at the last index keeps idx from wrapping.
   function automatic logic [CNT_W-1:0] last_idx(input logic [CNT_W-1:0] t);
      return (t == '0) ? {CNT_W{1'b1}} : t - 1'b1;
   endfunction

   function automatic logic [HOLD_W:0] hold_len(input logic [HOLD_W-1:0] h);
      return (h == '0) ? (HOLD_W+1)'(1) : {1'b0, h};
   endfunction

endpackage

// File: rtl/tof_detector.sv
// Echo detector: blanks ringdown, confirms a run of hold hits, tracks the echo peak, reports tof.
// Latency: done and results register on the terminating sample's edge; no backpressure, en-strobed.
module tof_detector
   import tof_pkg::*;
#(
   parameter int N = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [N-1:0]      Y,
   input  logic              start,
   input  logic [N-1:0]      threshold,
   input  logic [CNT_W-1:0]  blank,
   input  logic [HOLD_W-1:0] hold,
   input  logic [CNT_W-1:0]  timeout,
   output logic              busy,
   output logic              done,
   output logic              hit,
   output logic [CNT_W-1:0]  tof,
   output logic [N-1:0]      peak
);

   tof_state_e        state_q, state_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
   logic [HOLD_W-1:0] run_q, run_d;
   logic [N-1:0]      pk_tmp_q, pk_tmp_d;
   logic [CNT_W-1:0]  start_idx_q, start_idx_d;
   logic [CNT_W-1:0]  tof_tmp_q, tof_tmp_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              hit_q, hit_d;
   logic [CNT_W-1:0]  tof_q, tof_d;
   logic [N-1:0]      peak_q, peak_d;

   logic              y_hit;
   logic [N-1:0]      pk_max;
   logic              at_limit;
   logic              run_done;
   logic              end_hit;
   logic              end_miss;

   assign y_hit    = (Y >= threshold);
   assign pk_max   = (Y > pk_tmp_q) ? Y : pk_tmp_q;
   assign at_limit = (idx_q == last_idx(timeout));
   assign run_done = (({1'b0, run_q} + 5'd1) == hold_len(hold));

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      run_d       = run_q;
      pk_tmp_d    = pk_tmp_q;
      start_idx_d = start_idx_q;
      tof_tmp_d   = tof_tmp_q;
      hit_d       = hit_q;
      tof_d       = tof_q;
      peak_d      = peak_q;
      end_hit     = 1'b0;
      end_miss    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               idx_d    = '0;
               run_d    = '0;
               pk_tmp_d = '0;
               state_d  = (blank != '0) ? ST_BLANK : ST_SEARCH;
            end
         end
         ST_BLANK: begin
            if (en) begin
               if (!at_limit) idx_d = idx_q + 1'b1;
               if (idx_q == blank - 1'b1) state_d = ST_SEARCH;
               end_miss = at_limit;
            end
         end
         ST_SEARCH: begin
            if (en) begin
               if (!at_limit) idx_d = idx_q + 1'b1;
               if (y_hit) begin
                  run_d    = run_q + 1'b1;
                  pk_tmp_d = pk_max;
                  if (run_q == '0) start_idx_d = idx_q;
                  if (run_done) begin
                     state_d   = ST_PEAK;
                     tof_tmp_d = (run_q == '0) ? idx_q : start_idx_q;
                  end
               end else begin
                  run_d    = '0;
                  pk_tmp_d = '0;
               end
               // A run confirmed on the window's last sample still counts as an echo.
               if (at_limit) begin
                  if (y_hit && run_done) end_hit = 1'b1;
                  else end_miss = 1'b1;
               end
            end
         end
         ST_PEAK: begin
            if (en) begin
               if (!at_limit) idx_d = idx_q + 1'b1;
               if (y_hit) pk_tmp_d = pk_max;
               end_hit = !y_hit || at_limit;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (end_hit) begin
         state_d = ST_DONE;
         hit_d   = 1'b1;
         tof_d   = tof_tmp_d;
         peak_d  = pk_tmp_d;
      end
      if (end_miss) begin
         state_d = ST_DONE;
         hit_d   = 1'b0;
         tof_d   = timeout;
         peak_d  = '0;
      end

      busy_d = (state_d == ST_BLANK) || (state_d == ST_SEARCH) || (state_d == ST_PEAK);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         run_q       <= '0;
         pk_tmp_q    <= '0;
         start_idx_q <= '0;
         tof_tmp_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         hit_q       <= 1'b0;
         tof_q       <= '0;
         peak_q      <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         run_q       <= run_d;
         pk_tmp_q    <= pk_tmp_d;
         start_idx_q <= start_idx_d;
         tof_tmp_q   <= tof_tmp_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         hit_q       <= hit_d;
         tof_q       <= tof_d;
         peak_q      <= peak_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hit  = hit_q;
   assign tof  = tof_q;
   assign peak = peak_q;

endmodule

// File: doc/tof_detector.md
TOF_DETECTOR -- requirements
Module: tof_detector

Interface
REQ-001 SHALL have parameter N, default 16, meaning the width of the sample and threshold inputs and of the peak output.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port en, input, 1 bit: sample strobe, the same enable that advances the upstream filter.
REQ-005 SHALL have port Y, input, N bits: unsigned filtered sample, valid when en=1.
REQ-006 SHALL have port start, input, 1 bit: single-cycle pulse that arms a measurement, issued at burst transmit.
REQ-007 SHALL have port threshold, input, N bits: detection level; a sample hits when Y >= threshold.
REQ-008 SHALL have port blank, input, 16 bits: number of leading samples ignored to skip ringdown.
REQ-009 SHALL have port hold, input, 4 bits: consecutive hit samples needed to confirm an echo; 0 is treated as 1.
REQ-010 SHALL have port timeout, input, 16 bits: window length in samples; 0 means no limit.
REQ-011 SHALL have port busy, output, 1 bit: high in BLANK, SEARCH and PEAK.
REQ-012 SHALL have port done, output, 1 bit: single-cycle pulse when a measurement ends.
REQ-013 SHALL have port hit, output, 1 bit: last measurement confirmed an echo.
REQ-014 SHALL have port tof, output, 16 bits: sample index of the first sample of the confirming run.
REQ-015 SHALL have port peak, output, N bits: maximum Y over the echo.

Function
REQ-016 SHALL use states IDLE, BLANK, SEARCH, PEAK and DONE.
REQ-017 SHALL, in IDLE on start=1, clear idx, run and pk_tmp, then go to BLANK if blank>0, else to SEARCH.
REQ-018 SHALL ignore start outside IDLE, and SHALL ignore en in IDLE and DONE.
REQ-019 SHALL number accepted samples by idx, starting at 0 and incrementing by 1 per en in BLANK, SEARCH and PEAK.
REQ-020 SHALL, in BLANK, move to SEARCH on the en whose idx equals blank-1; samples in BLANK are never compared.
REQ-021 SHALL, in SEARCH on en with a hit: set run to run+1, set pk_tmp to max(pk_tmp, Y), and latch start_idx=idx when run was 0.
REQ-022 SHALL, in SEARCH on en without a hit: set run to 0 and pk_tmp to 0.
REQ-023 SHALL move SEARCH to PEAK when run+1 reaches max(hold,1), and SHALL then capture tof_tmp=start_idx.
REQ-024 SHALL, in PEAK on en with a hit, set pk_tmp to max(pk_tmp, Y).
REQ-025 SHALL move PEAK to DONE on the first en without a hit, with hit result 1.
REQ-026 SHALL, when timeout≠0, go to DONE on the en whose idx equals timeout-1, from BLANK, SEARCH or PEAK; that sample is processed first.
REQ-027 SHALL, on timeout from PEAK, give hit=1; from BLANK or SEARCH, give hit=0, tof=timeout and peak=0.
REQ-028 SHALL, when timeout=0, treat idx=0xFFFF as the timeout sample, so idx never wraps.
REQ-029 SHALL give a hold run cut short by timeout hit=0.
REQ-030 SHALL update hit, tof and peak on the same edge that enters DONE, and hold them until the next DONE.
REQ-031 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-032 SHALL give a latency of 1 clk from the terminating en edge to done=1.
REQ-033 SHALL evaluate the threshold comparison as unsigned N-bit, and SHALL make pk_tmp N bits with no overflow.
REQ-034 SHALL sample threshold, blank, hold and timeout every cycle; software changes them only while busy=0.

Reset
REQ-035 SHALL, when rst=0 at a clk edge, go to IDLE, set busy, done and hit to 0, and clear tof, peak, idx, run, start_idx and pk_tmp, regardless of state.
REQ-036 SHALL produce no done pulse for a reset taken mid-measurement, and SHALL ignore start while rst=0.

Structure
REQ-037 SHALL place the state enumeration, the 16-bit count width and the 4-bit hold width in shared package tof_pkg.
REQ-038 SHALL be a single module with no sub-module; the peak max and run counter are inline.

Verification
REQ-039 SHALL cover: blank=4, hold=2, threshold=100, timeout=50, Y=0 except idx 10..13 = 120,200,150,90 -> done at idx13+1clk, hit=1, tof=10, peak=200.
REQ-040 SHALL cover: hold=3, hits at idx 5,6 only, then idx 20..22 = 110 -> tof=20, peak=110; the run at 5..6 discarded.
REQ-041 SHALL cover: blank=8, Y=500 at idx 3..7 then 0, timeout=30 -> hit=0, tof=30, peak=0, done after idx 29.
REQ-042 SHALL cover: hold=0, threshold=0 -> tof=blank, and done on the timeout sample, since every sample hits.
REQ-043 SHALL cover: rst=0 pulse while in PEAK -> IDLE next cycle, no done, outputs 0; the next start measures cleanly.
REQ-044 SHALL cover: start pulsed while busy, and en held high every cycle versus en every 4th cycle -> identical tof and peak.
